// File: rtl/counter_share_sched_if.sv
// Requester-side bundle for the shared counter scheduler: requests, job lengths,
// run controls, and the grant/completion status returned by the scheduler.
interface counter_share_sched_if #(
   parameter int NREQ = 4,
   parameter int CW   = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic               hold;
   logic               abort;
   logic [NREQ-1:0]    grant;
   logic               busy;
   logic [CW-1:0]      count_out;
   logic               done;
   logic [IDW-1:0]     done_id;
   logic               done_abort;

   modport master (
      output req, len, hold, abort,
      input  grant, busy, count_out, done, done_id, done_abort
   );

   modport slave (
      input  req, len, hold, abort,
      output grant, busy, count_out, done, done_id, done_abort
   );
endinterface

// File: rtl/counter_share_sched.sv
// Round-robin owner of one up-counter: each granted requester runs a job that
// counts 0..len (or until abort), then a one-cycle done pulse reports it.
module counter_share_sched #(
   parameter int NREQ = 4,
   parameter int CW   = 4,
   parameter int IDW  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   counter_share_sched_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_sel;
   logic [IDW-1:0]  r_rr_last;
   logic [IDW-1:0]  r_done_id;
   logic [CW-1:0]   r_len;
   logic [CW-1:0]   r_count;
   logic [NREQ-1:0] r_grant;
   logic            r_busy;
   logic            r_done;
   logic            r_done_abort;

   logic [IDW-1:0]  w_cand [NREQ];
   logic [CW-1:0]   w_len_arr [NREQ];
   logic [IDW-1:0]  w_sel;
   logic [CW-1:0]   w_len;
   logic            w_found;
   logic            w_finish;

   // Candidates are visited starting just after the last served requester.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand[k]    = IDW'((int'(r_rr_last) + k + 1) % NREQ);
         w_len_arr[k] = bus.len[k*CW +: CW];
      end
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && bus.req[w_cand[k]]) begin
            w_sel   = w_cand[k];
            w_found = 1'b1;
         end
      end
      w_len = w_len_arr[w_sel];
   end

   // Abort overrides hold; terminal count only completes on a non-hold cycle.
   assign w_finish = bus.abort || (!bus.hold && (r_count == r_len));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_sel        <= '0;
         r_rr_last    <= IDW'(NREQ - 1);
         r_done_id    <= '0;
         r_len        <= '0;
         r_count      <= '0;
         r_grant      <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_done_abort <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_sel   <= w_sel;
                  r_len   <= w_len;
                  r_grant <= NREQ'(1) << w_sel;
                  r_busy  <= 1'b1;
                  r_count <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_finish) begin
                  r_state      <= S_DONE;
                  r_done       <= 1'b1;
                  r_done_id    <= r_sel;
                  r_done_abort <= bus.abort;
                  r_grant      <= '0;
                  r_busy       <= 1'b0;
                  r_rr_last    <= r_sel;
               end else if (!bus.hold) begin
                  r_count <= r_count + 1'b1;
               end
            end
            S_DONE: begin
               r_done       <= 1'b0;
               r_done_abort <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.grant      = r_grant;
   assign bus.busy       = r_busy;
   assign bus.count_out  = r_count;
   assign bus.done       = r_done;
   assign bus.done_id    = r_done_id;
   assign bus.done_abort = r_done_abort;

endmodule

// File: tb/tb_counter_share_sched.sv
// Directed bench for counter_share_sched: stimulus queues expected grants and
// completions, an independent monitor pops and compares them as the DUT reports.
module tb_counter_share_sched;
   localparam int NREQ = 4;
   localparam int CW   = 4;
   localparam int IDW  = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           ab;
      logic [CW-1:0]  cnt;
   } done_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   counter_share_sched_if #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) bus();

   counter_share_sched #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   done_t           exp_done  [$];
   logic [NREQ-1:0] exp_grant [$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic push_grant(input logic [NREQ-1:0] g);
      exp_grant.push_back(g);
   endtask

   task automatic push_done(input int id, input logic ab, input int cnt);
      done_t d;
      d.id  = IDW'(id);
      d.ab  = ab;
      d.cnt = CW'(cnt);
      exp_done.push_back(d);
   endtask

   // Monitor: compares DUT-presented events against the queued expectations.
   initial begin
      done_t d;
      logic  prev_busy;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         chk("busy_eq_grant_nonzero", bus.busy, (bus.grant != '0));
         chk("grant_onehot0", $onehot0(bus.grant), 1);
         if (bus.done) begin
            if (exp_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done_id=%0d, expected no done", bus.done_id);
            end else begin
               d = exp_done.pop_front();
               chk("done_id", bus.done_id, d.id);
               chk("done_abort", bus.done_abort, d.ab);
               chk("done_count", bus.count_out, d.cnt);
               chk("done_grant_zero", bus.grant, 0);
            end
         end
         if (bus.busy && !prev_busy) begin
            if (exp_grant.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_grant: got grant=%0b, expected none", bus.grant);
            end else begin
               chk("grant", bus.grant, exp_grant.pop_front());
               chk("grant_count_zero", bus.count_out, 0);
            end
         end
         prev_busy = bus.busy;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < max);
      if (!bus.done) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done=1", n);
      end
   endtask

   task automatic wait_count(input logic [CW-1:0] v, input int max);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.busy && bus.count_out == v) && n < max);
      if (!(bus.busy && bus.count_out == v)) begin
         checks++; errors++;
         $display("FAIL count_timeout: got count_out=%0d, expected %0d", bus.count_out, v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bus.req = '0; bus.len = '0; bus.hold = 1'b0; bus.abort = 1'b0;

      // Test 1: reset held with all requests asserted
      #1 reset = 1'b0;
      bus.req = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         chk("rst_grant", bus.grant, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_count", bus.count_out, 0);
         chk("rst_done", bus.done, 0);
      end
      push_grant(4'b0001);
      push_done(0, 1'b0, 0);
      @(posedge clk); #1 reset = 1'b1;
      cyc(1);
      bus.req = '0;
      wait_done(10, n);
      cyc(2);

      // Test 2: single job on requester 2, len 3
      bus.len[2*CW +: CW] = 4'd3;
      bus.req = 4'b0100;
      push_grant(4'b0100);
      push_done(2, 1'b0, 3);
      cyc(1);
      bus.req = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("run_count", bus.count_out, i);
         chk("run_grant", bus.grant, 4'b0100);
      end
      wait_done(4, n);
      chk("done_after_len3", n, 1);
      cyc(2);
      chk("idle_count_holds", bus.count_out, 3);

      // Test 3: round robin with all len=0 from fresh reset
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      bus.len = '0;
      bus.req = 4'b1111;
      push_grant(4'b0001); push_grant(4'b0010); push_grant(4'b0100);
      push_grant(4'b1000); push_grant(4'b0001);
      push_done(0, 1'b0, 0); push_done(1, 1'b0, 0); push_done(2, 1'b0, 0);
      push_done(3, 1'b0, 0); push_done(0, 1'b0, 0);
      wait_done(10, n);
      for (int k = 0; k < 3; k++) begin
         wait_done(10, n);
         chk("rr_period", n, 3);
      end
      @(posedge clk); @(posedge clk); #1;
      bus.req = '0;
      wait_done(10, n);
      chk("rr_last_job", n, 2);
      cyc(2);

      // Test 4: hold at 7, full range to 15
      bus.len[1*CW +: CW] = 4'd15;
      bus.req = 4'b0010;
      push_grant(4'b0010);
      push_done(1, 1'b0, 15);
      cyc(1);
      bus.req = '0;
      wait_count(4'd7, 20);
      bus.hold = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_count", bus.count_out, 7);
      end
      bus.hold = 1'b0;
      wait_done(20, n);
      chk("full_range_cycles", n, 9);
      cyc(2);

      // Test 5: abort with hold at count 4
      bus.len[0*CW +: CW] = 4'd10;
      bus.req = 4'b0001;
      push_grant(4'b0001);
      push_done(0, 1'b1, 4);
      cyc(1);
      bus.req = '0;
      wait_count(4'd4, 20);
      bus.abort = 1'b1;
      bus.hold  = 1'b1;
      wait_done(3, n);
      chk("abort_latency", n, 1);
      bus.abort = 1'b0;
      bus.hold  = 1'b0;
      cyc(2);

      // Test 6: asynchronous reset mid-job
      bus.len[2*CW +: CW] = 4'd12;
      bus.req = 4'b0100;
      push_grant(4'b0100);
      cyc(1);
      bus.req = '0;
      wait_count(4'd6, 20);
      reset = 1'b0;
      #1;
      chk("async_grant", bus.grant, 0);
      chk("async_busy", bus.busy, 0);
      chk("async_count", bus.count_out, 0);
      chk("async_done", bus.done, 0);
      repeat (2) @(posedge clk);
      #1;
      bus.len[1*CW +: CW] = 4'd2;
      bus.req = 4'b0010;
      push_grant(4'b0010);
      push_done(1, 1'b0, 2);
      reset = 1'b1;
      cyc(1);
      bus.req = '0;
      wait_done(10, n);
      chk("post_reset_job", n, 4);
      cyc(2);

      chk("exp_done_empty", exp_done.size(), 0);
      chk("exp_grant_empty", exp_grant.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/counter_share_sched.md
Name: counter_share_sched

Overview:
- Round-robin scheduler that shares one 4-bit up-counter between NREQ requesters.
- Each granted requester gets one counting job: the counter clears to 0, increments to the requester's length value, then the job completes.
- Sits in front of the counter datapath, which it owns internally, and reports per-job completion back to requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 4, counter width in bits.
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- req, input, NREQ, per-requester job request (level).
- len, input, NREQ*CW, packed terminal counts; requester i at bits [i*CW +: CW].
- hold, input, 1, pauses counting while 1.
- abort, input, 1, terminates the running job.
- grant, output, NREQ, one-hot owner of the counter during RUN; otherwise 0.
- busy, output, 1, 1 while in RUN.
- count_out, output, CW, current counter value.
- done, output, 1, one-cycle completion pulse.
- done_id, output, IDW, index of the completed requester; valid when done=1.
- done_abort, output, 1, qualifies done: 1 = job was aborted.

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, busy=0, count_out=0, done=0, done_id=0, done_abort=0, rr_last=NREQ-1 (requester 0 has first priority). Outputs stay at these values while reset is low; leaving reset is synchronous to clk.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If req is nonzero, select the first asserted index scanning rr_last+1, rr_last+2, ... modulo NREQ.
  - Capture the selected len into an internal register; later len changes are ignored.
  - Next cycle: RUN, grant=onehot(sel), busy=1, count_out=0.
  - If req=0: stay in IDLE.
- RUN (evaluated each clk, in priority order):
  1. abort=1 -> DONE, done_abort=1.
  2. hold=1 -> no change.
  3. count_out == captured len -> DONE, done_abort=0.
  4. Otherwise count_out <= count_out+1.
  - A job takes len+1 non-hold RUN cycles. len=0 gives 1 RUN cycle; len=2**CW-1 reaches all-ones and completes with no wrap.
  - The counter never wraps. Increments are modulo 2**CW but can never reach terminal+1.
- DONE (1 cycle):
  - done=1, done_id=sel, grant=0, busy=0, rr_last<=sel, count_out holds its final value.
  - Next state is IDLE. done and done_abort return to 0.
  - count_out clears to 0 on the next grant only.
- req is sampled only in IDLE. Deasserting the owner's req during RUN does not end the job; only terminal count or abort does. A requester still asserting req after its DONE is eligible again, but it is lowest priority for the next arbitration.
- Throughput: minimum job period is len+3 cycles (IDLE arbitration, len+1 RUN, DONE).
- abort outside RUN is ignored. hold outside RUN is ignored. abort together with hold in RUN: abort wins.
- Reset asserted mid-job: immediate return to reset values, no done pulse, and the round-robin pointer resets.
- grant is always zero or one-hot. busy equals (grant != 0).

Test Plan:
1. Reset low for 3 cycles with req=4'b1111 -> grant=0, busy=0, count_out=0, done=0. Release reset -> first grant=4'b0001.
2. Single job: req=4'b0100, len[2]=3 -> grant=4'b0100 for 4 RUN cycles with count_out 0,1,2,3. Then done=1, done_id=2, done_abort=0 for 1 cycle, then IDLE.
3. Round robin: req=4'b1111 held, all len=0 -> grant order 0,1,2,3,0. Each job is 3 cycles and done_id follows the same order.
4. Hold and full range: len[1]=15, hold=1 for 5 cycles while count_out=7 -> count_out holds 7. The job completes after 16 non-hold RUN cycles at count_out=15 with no wrap.
5. Abort: len[0]=10, abort=1 while count_out=4 (with hold=1 in the same cycle) -> next cycle done=1, done_abort=1, done_id=0, count_out=4.
6. Reset mid-job: reset low while count_out=6 -> asynchronously grant=0, busy=0, count_out=0, and no done pulse. With req=4'b0010 after release -> grant=4'b0010.
